// File: rtl/jtkicker_tilefetch_if.sv
// VRAM read port and SDRAM tile ROM port between the scroll tile fetcher (master)
// and the memory side (slave).
interface jtkicker_tilefetch_if #(
  parameter int ROM_AW = 13
);
  logic [9:0]        vram_addr;
  logic [7:0]        code;
  logic [7:0]        attr;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_cs;
  logic [31:0]       rom_data;
  logic              rom_ok;

  modport master (
    output vram_addr, rom_addr, rom_cs,
    input  code, attr, rom_data, rom_ok
  );

  modport slave (
    input  vram_addr, rom_addr, rom_cs,
    output code, attr, rom_data, rom_ok
  );
endinterface

// File: rtl/jtkicker_tilefetch.sv
// Scroll-layer tile fetcher: VRAM code/attr read, SDRAM tile row request, 4bpp pixel shifter.
// Defining JTKICKER_HSCROLL_EN adds an hscroll input latched once per line at LHBL fall.
//
// state  | meaning
// IDLE   | waiting for the fetch trigger of the next column
// VRD    | vram_addr presented to VRAM
// VWAIT  | code/attr valid, ROM address formed
// ROMREQ | rom_cs high, waiting for rom_ok
// READY  | tile row buffered until the load point
module jtkicker_tilefetch #(
  parameter int         ROM_AW    = 13,
  parameter logic [7:0] BLANK_PXL = 8'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pxl_cen,
  input  logic                  LHBL,
  input  logic                  LVBL,
  input  logic [7:0]            hdump,
  input  logic [7:0]            vdump,
  input  logic                  flip,
`ifdef JTKICKER_HSCROLL_EN
  input  logic [7:0]            hscroll,
`endif
  jtkicker_tilefetch_if.master  mem,
  output logic [7:0]            pxl,
  output logic                  miss
);

  typedef enum logic [2:0] {IDLE, VRD, VWAIT, ROMREQ, READY} state_t;

  localparam logic [31:0] BLANK_ROW = {8{BLANK_PXL[3:0]}};
  localparam logic [3:0]  BLANK_PAL = BLANK_PXL[7:4];

  state_t            state_q, state_d;
  logic [9:0]        vram_addr_q, vram_addr_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              rom_cs_q, rom_cs_d;
  logic [1:0]        wait_q, wait_d;
  logic [4:0]        attr_q, attr_d;
  logic [31:0]       buf_data_q, buf_data_d;
  logic [3:0]        buf_pal_q, buf_pal_d;
  logic              buf_rev_q, buf_rev_d;
  logic [31:0]       sh_data_q, sh_data_d;
  logic [3:0]        sh_pal_q, sh_pal_d;
  logic              sh_rev_q, sh_rev_d;
  logic [7:0]        pxl_q, pxl_d;
  logic              miss_q, miss_d;

  logic [7:0]        hoff;
  logic [7:0]        vdf;
  logic [7:0]        hcnt;
  logic [4:0]        nxt;
  logic              trig;
  logic              load;

`ifdef JTKICKER_HSCROLL_EN
  logic [7:0] hscroll_q, hscroll_d;
  logic       lhbl_q, lhbl_d;

  always_comb begin
    lhbl_d    = LHBL;
    hscroll_d = (lhbl_q && !LHBL) ? hscroll : hscroll_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hscroll_q <= 8'd0;
      lhbl_q    <= 1'b0;
    end else begin
      hscroll_q <= hscroll_d;
      lhbl_q    <= lhbl_d;
    end
  end

  assign hoff = hscroll_q;
`else
  assign hoff = 8'd0;
`endif

  always_comb begin
    vdf  = vdump ^ {8{flip}};
    hcnt = (hdump ^ {8{flip}}) + hoff;
    nxt  = flip ? hcnt[7:3] - 5'd1 : hcnt[7:3] + 5'd1;
    trig = pxl_cen && (hcnt[2:0] == (flip ? 3'd7 : 3'd0));
    load = pxl_cen && (hcnt[2:0] == (flip ? 3'd0 : 3'd7));

    state_d     = state_q;
    vram_addr_d = vram_addr_q;
    rom_addr_d  = rom_addr_q;
    rom_cs_d    = rom_cs_q;
    wait_d      = wait_q;
    attr_d      = attr_q;
    buf_data_d  = buf_data_q;
    buf_pal_d   = buf_pal_q;
    buf_rev_d   = buf_rev_q;
    sh_data_d   = sh_data_q;
    sh_pal_d    = sh_pal_q;
    sh_rev_d    = sh_rev_q;
    pxl_d       = pxl_q;
    miss_d      = 1'b0;

    case (state_q)
      VRD: state_d = VWAIT;
      VWAIT: begin
        attr_d     = mem.attr[4:0];
        rom_addr_d = ROM_AW'({mem.attr[7:6], mem.code, vdf[2:0] ^ {3{mem.attr[5]}}});
        rom_cs_d   = 1'b1;
        wait_d     = 2'd2;
        state_d    = ROMREQ;
      end
      ROMREQ: begin
        // rom_ok in the first two cycles may still belong to the previous address
        if (wait_q != 2'd0) begin
          wait_d = wait_q - 2'd1;
        end else if (mem.rom_ok) begin
          buf_data_d = mem.rom_data;
          buf_pal_d  = attr_q[3:0];
          buf_rev_d  = attr_q[4] ^ flip;
          rom_cs_d   = 1'b0;
          state_d    = READY;
        end
      end
      default: ;
    endcase

    if (load) begin
      if (state_q == READY) begin
        sh_data_d = buf_data_q;
        sh_pal_d  = buf_pal_q;
        sh_rev_d  = buf_rev_q;
      end else begin
        sh_data_d = BLANK_ROW;
        sh_pal_d  = BLANK_PAL;
        sh_rev_d  = 1'b0;
        miss_d    = 1'b1;
      end
      rom_cs_d = 1'b0;
      state_d  = IDLE;
    end

    if (trig && (state_q == IDLE || load)) begin
      vram_addr_d = {vdf[7:3], nxt};
      state_d     = VRD;
    end

    // The load-point cen still emits the last pixel of the outgoing row
    if (pxl_cen) begin
      pxl_d = (!LHBL || !LVBL) ? BLANK_PXL
            : {sh_pal_q, sh_rev_q ? sh_data_q[31:28] : sh_data_q[3:0]};
      if (!load) begin
        sh_data_d = sh_rev_q ? {sh_data_q[27:0], 4'h0} : {4'h0, sh_data_q[31:4]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vram_addr_q <= '0;
      rom_addr_q  <= '0;
      rom_cs_q    <= 1'b0;
      wait_q      <= 2'd0;
      attr_q      <= '0;
      buf_data_q  <= '0;
      buf_pal_q   <= '0;
      buf_rev_q   <= 1'b0;
      sh_data_q   <= '0;
      sh_pal_q    <= '0;
      sh_rev_q    <= 1'b0;
      pxl_q       <= BLANK_PXL;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vram_addr_q <= vram_addr_d;
      rom_addr_q  <= rom_addr_d;
      rom_cs_q    <= rom_cs_d;
      wait_q      <= wait_d;
      attr_q      <= attr_d;
      buf_data_q  <= buf_data_d;
      buf_pal_q   <= buf_pal_d;
      buf_rev_q   <= buf_rev_d;
      sh_data_q   <= sh_data_d;
      sh_pal_q    <= sh_pal_d;
      sh_rev_q    <= sh_rev_d;
      pxl_q       <= pxl_d;
      miss_q      <= miss_d;
    end
  end

  assign mem.vram_addr = vram_addr_q;
  assign mem.rom_addr  = rom_addr_q;
  assign mem.rom_cs    = rom_cs_q;
  assign pxl           = pxl_q;
  assign miss          = miss_q;

endmodule

// File: tb/tb_jtkicker_tilefetch.sv
// Directed bench for the scroll tile fetcher: simple VRAM/ROM responders and a free-running pixel counter.
module tb_jtkicker_tilefetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        pxl_cen;
  logic        LHBL;
  logic        LVBL;
  logic        flip;
  logic [7:0]  hdump;
  logic [7:0]  vdump;
  logic [7:0]  pxl;
  logic        miss;
`ifdef JTKICKER_HSCROLL_EN
  logic [7:0]  hscroll;
`endif

  logic [2:0]  cen_cnt;
  logic [7:0]  vcode;
  logic [7:0]  vattr;
  logic [31:0] rdata;
  logic        rom_en;
  logic [7:0]  exp_pxl;
  int          cs_cnt;
  int          miss_cnt;
  int          checks;
  int          errors;

  jtkicker_tilefetch_if #(.ROM_AW(13)) mem();

  jtkicker_tilefetch #(.ROM_AW(13), .BLANK_PXL(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen),
    .LHBL    (LHBL),
    .LVBL    (LVBL),
    .hdump   (hdump),
    .vdump   (vdump),
    .flip    (flip),
`ifdef JTKICKER_HSCROLL_EN
    .hscroll (hscroll),
`endif
    .mem     (mem),
    .pxl     (pxl),
    .miss    (miss)
  );

  initial forever #5 clk = ~clk;

  task automatic drive_mem();
    mem.code     = vcode;
    mem.attr     = vattr;
    mem.rom_data = rdata;
    mem.rom_ok   = rom_en && mem.rom_cs;
  endtask

  // One clock; hdump advances after each cen edge, cen every 8th clock
  task automatic clk1();
    @(posedge clk);
    #1;
    if (pxl_cen) hdump = hdump + 8'd1;
    cen_cnt = cen_cnt + 3'd1;
    pxl_cen = (cen_cnt == 3'd7);
    drive_mem();
    if (mem.rom_cs) cs_cnt++;
    if (miss) miss_cnt++;
  endtask

  task automatic set_pos(input logic [7:0] h);
    hdump   = h;
    cen_cnt = 3'd7;
    pxl_cen = 1'b1;
  endtask

  task automatic step_cen();
    logic was;
    int   n;
    n = 0;
    do begin
      was = pxl_cen;
      clk1();
      n++;
    end while (!was && n < 16);
  endtask

  task automatic goto_cen(input logic [7:0] h);
    int n;
    n = 0;
    while (!(pxl_cen && hdump == h) && n < 4000) begin
      clk1();
      n++;
    end
    checks++;
    if (!(pxl_cen && hdump == h)) begin
      errors++;
      $display("FAIL goto_cen: hdump %h not reached, at %h", h, hdump);
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    clk1();
    clk1();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) clk1();
    checks++; if (pxl !== 8'h00) begin errors++; $display("FAIL reset_pxl: got %h expected %h", pxl, 8'h00); end
    checks++; if (mem.rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs: got %b expected 0", mem.rom_cs); end
    checks++; if (miss !== 1'b0) begin errors++; $display("FAIL reset_miss: got %b expected 0", miss); end
    checks++; if (mem.vram_addr !== 10'h000) begin errors++; $display("FAIL reset_vram_addr: got %h expected 000", mem.vram_addr); end
    checks++; if (mem.rom_addr !== 13'h0000) begin errors++; $display("FAIL reset_rom_addr: got %h expected 0000", mem.rom_addr); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    vdump = 8'h0A; flip = 1'b0; vcode = 8'h5A; vattr = 8'h03;
    rdata = 32'h76543210; rom_en = 1'b1;
    rst_pulse();
    set_pos(8'h08);
    cs_cnt = 0;
    clk1();
    checks++; if (mem.vram_addr !== 10'h022) begin errors++; $display("FAIL fetch_vram_addr: got %h expected %h", mem.vram_addr, 10'h022); end
    clk1();
    clk1();
    checks++; if (mem.rom_addr !== 13'h02D2) begin errors++; $display("FAIL fetch_rom_addr: got %h expected %h", mem.rom_addr, 13'h02D2); end
    checks++; if (mem.rom_cs !== 1'b1) begin errors++; $display("FAIL fetch_rom_cs_high: got %b expected 1", mem.rom_cs); end
    repeat (6) clk1();
    checks++; if (cs_cnt != 3) begin errors++; $display("FAIL fetch_cs_cycles: got %0d expected 3", cs_cnt); end
    checks++; if (mem.rom_cs !== 1'b0) begin errors++; $display("FAIL fetch_rom_cs_low: got %b expected 0", mem.rom_cs); end
  endtask

  task automatic test_pixels();
    goto_cen(8'h0F);
    step_cen();
    checks++; if (miss !== 1'b0) begin errors++; $display("FAIL pixels_no_miss: got %b expected 0", miss); end
    vattr = 8'h13;
    for (int k = 0; k < 8; k++) begin
      step_cen();
      exp_pxl = 8'h30 + k[7:0];
      checks++; if (pxl !== exp_pxl) begin errors++; $display("FAIL pixels_fwd[%0d]: got %h expected %h", k, pxl, exp_pxl); end
    end
    for (int k = 0; k < 8; k++) begin
      step_cen();
      exp_pxl = 8'h37 - k[7:0];
      checks++; if (pxl !== exp_pxl) begin errors++; $display("FAIL pixels_hflip[%0d]: got %h expected %h", k, pxl, exp_pxl); end
    end
  endtask

  task automatic test_miss();
    rom_en = 1'b0;
    miss_cnt = 0;
    goto_cen(8'h27);
    step_cen();
    checks++; if (miss !== 1'b1) begin errors++; $display("FAIL miss_pulse: got %b expected 1", miss); end
    checks++; if (mem.rom_cs !== 1'b0) begin errors++; $display("FAIL miss_rom_cs: got %b expected 0", mem.rom_cs); end
    rom_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step_cen();
      checks++; if (pxl !== 8'h00) begin errors++; $display("FAIL miss_blank[%0d]: got %h expected 00", k, pxl); end
    end
    for (int k = 0; k < 8; k++) begin
      step_cen();
      exp_pxl = 8'h37 - k[7:0];
      checks++; if (pxl !== exp_pxl) begin errors++; $display("FAIL miss_recover[%0d]: got %h expected %h", k, pxl, exp_pxl); end
    end
    checks++; if (miss_cnt != 1) begin errors++; $display("FAIL miss_count: got %0d expected 1", miss_cnt); end
  endtask

  task automatic test_reset_mid_romreq();
    rom_en = 1'b0;
    step_cen();
    clk1();
    clk1();
    checks++; if (mem.rom_cs !== 1'b1) begin errors++; $display("FAIL rstmid_pre_cs: got %b expected 1", mem.rom_cs); end
    rst = 1'b1;
    clk1();
    checks++; if (mem.rom_cs !== 1'b0) begin errors++; $display("FAIL rstmid_rom_cs: got %b expected 0", mem.rom_cs); end
    repeat (3) clk1();
    checks++; if (pxl !== 8'h00) begin errors++; $display("FAIL rstmid_pxl: got %h expected 00", pxl); end
    checks++; if (miss !== 1'b0) begin errors++; $display("FAIL rstmid_miss: got %b expected 0", miss); end
    checks++; if (mem.vram_addr !== 10'h000) begin errors++; $display("FAIL rstmid_vram_addr: got %h expected 000", mem.vram_addr); end
    checks++; if (mem.rom_addr !== 13'h0000) begin errors++; $display("FAIL rstmid_rom_addr: got %h expected 0000", mem.rom_addr); end
    rst = 1'b0;
    rom_en = 1'b1;
  endtask

  task automatic test_flip();
    flip = 1'b1; vdump = 8'h00; vcode = 8'h5A; vattr = 8'h23;
    rst_pulse();
    set_pos(8'h00);
    clk1();
    checks++; if (mem.vram_addr !== 10'h3FE) begin errors++; $display("FAIL flip_vram_addr: got %h expected %h", mem.vram_addr, 10'h3FE); end
    clk1();
    clk1();
    checks++; if (mem.rom_addr !== 13'h02D0) begin errors++; $display("FAIL flip_rom_addr: got %h expected %h", mem.rom_addr, 13'h02D0); end
    goto_cen(8'h07);
    step_cen();
    for (int k = 0; k < 8; k++) begin
      step_cen();
      exp_pxl = 8'h37 - k[7:0];
      checks++; if (pxl !== exp_pxl) begin errors++; $display("FAIL flip_pixels[%0d]: got %h expected %h", k, pxl, exp_pxl); end
    end
  endtask

  task automatic test_blank();
    step_cen();
    LHBL = 1'b0;
    step_cen();
    checks++; if (pxl !== 8'h00) begin errors++; $display("FAIL blank_lhbl: got %h expected 00", pxl); end
    LHBL = 1'b1;
    LVBL = 1'b0;
    step_cen();
    checks++; if (pxl !== 8'h00) begin errors++; $display("FAIL blank_lvbl: got %h expected 00", pxl); end
    LVBL = 1'b1;
    step_cen();
    checks++; if (pxl !== 8'h34) begin errors++; $display("FAIL blank_resume: got %h expected 34", pxl); end
  endtask

`ifdef JTKICKER_HSCROLL_EN
  task automatic test_hscroll();
    flip = 1'b0; vdump = 8'h0A; hscroll = 8'h08;
    rst_pulse();
    LHBL = 1'b1;
    clk1();
    LHBL = 1'b0;
    clk1();
    hscroll = 8'h40;
    set_pos(8'h00);
    clk1();
    checks++; if (mem.vram_addr !== 10'h022) begin errors++; $display("FAIL hscroll_vram_addr: got %h expected %h", mem.vram_addr, 10'h022); end
    step_cen();
    checks++; if (pxl !== 8'h00) begin errors++; $display("FAIL hscroll_blank: got %h expected 00", pxl); end
    LHBL = 1'b1;
  endtask
`endif

  initial begin
    checks = 0; errors = 0; cs_cnt = 0; miss_cnt = 0;
    rst = 1'b1; LHBL = 1'b1; LVBL = 1'b1; flip = 1'b0;
    hdump = 8'h00; vdump = 8'h00; cen_cnt = 3'd0; pxl_cen = 1'b0;
    vcode = 8'h00; vattr = 8'h00; rdata = 32'h0; rom_en = 1'b0;
`ifdef JTKICKER_HSCROLL_EN
    hscroll = 8'h00;
`endif
    drive_mem();
    test_reset();
    test_fetch();
    test_pixels();
    test_miss();
    test_reset_mid_romreq();
    test_flip();
    test_blank();
`ifdef JTKICKER_HSCROLL_EN
    test_hscroll();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
